// File: rtl/writeback_sequencer_if.sv
// writeback_sequencer_if: request, memory and register-file signals of the writeback sequencer
interface writeback_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  wb_source;
  logic [4:0]  rd_address_in;
  logic [31:0] alu_result;
  logic [31:0] pc_plus_4;
  logic [31:0] immediate;
  logic [2:0]  load_funct3;
  logic [1:0]  load_byte_offset;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] rd;
  logic        rd_write_enable;
  logic [4:0]  rd_address;
  logic        wb_done;
  logic        fault_misaligned;
  logic        fault_illegal;
  logic        fault_timeout;
  modport master (
    output instr_valid, wb_source, rd_address_in, alu_result, pc_plus_4, immediate,
           load_funct3, load_byte_offset, mem_ack, mem_rdata,
    input  instr_ready, mem_req, rd, rd_write_enable, rd_address, wb_done,
           fault_misaligned, fault_illegal, fault_timeout
  );
  modport slave (
    input  instr_valid, wb_source, rd_address_in, alu_result, pc_plus_4, immediate,
           load_funct3, load_byte_offset, mem_ack, mem_rdata,
    output instr_ready, mem_req, rd, rd_write_enable, rd_address, wb_done,
           fault_misaligned, fault_illegal, fault_timeout
  );
endinterface

// File: rtl/writeback_sequencer.sv
// writeback_sequencer: selects the writeback source, sequences loads and pulses the register-file write
module writeback_sequencer #(
  parameter int RV32I        = 1,
  parameter int LOAD_TIMEOUT = 255
) (
  input logic                  clock,
  input logic                  reset,
  writeback_sequencer_if.slave bus_io
);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, WRITE} state_t;
  localparam logic [9:0] TO_LAST = 10'(LOAD_TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        mem_req_q, mem_req_d;
  logic        we_q, we_d;
  logic        done_q, done_d;
  logic        fmis_q, fmis_d;
  logic        fill_q, fill_d;
  logic        fto_q, fto_d;
  logic [31:0] rd_q, rd_d;
  logic [4:0]  rda_q, rda_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        is_load, illegal, misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data, src_data;
  assign is_load    = bus_io.wb_source == 3'd4;
  assign illegal    = bus_io.wb_source > 3'd4
                    || (is_load && (bus_io.load_funct3[1:0] == 2'b11 || bus_io.load_funct3 == 3'd6))
                    || (RV32I == 0 && bus_io.rd_address_in[4]);
  assign misaligned = (bus_io.load_funct3[1:0] == 2'b01 && bus_io.load_byte_offset[0])
                    || (bus_io.load_funct3 == 3'd2 && bus_io.load_byte_offset != 2'd0);
  assign src_data   = bus_io.wb_source == 3'd1 ? bus_io.alu_result :
                      bus_io.wb_source == 3'd2 ? bus_io.pc_plus_4 : bus_io.immediate;
  assign ld_byte    = bus_io.mem_rdata[{off_q, 3'b000} +: 8];
  assign ld_half    = bus_io.mem_rdata[{off_q[1], 4'b0000} +: 16];
  assign ld_data    = f3_q == 3'd0 ? {{24{ld_byte[7]}}, ld_byte} :
                      f3_q == 3'd1 ? {{16{ld_half[15]}}, ld_half} :
                      f3_q == 3'd4 ? {24'd0, ld_byte} :
                      f3_q == 3'd5 ? {16'd0, ld_half} : bus_io.mem_rdata;
  assign bus_io.instr_ready      = ready_q;
  assign bus_io.mem_req          = mem_req_q;
  assign bus_io.rd               = rd_q;
  assign bus_io.rd_write_enable  = we_q;
  assign bus_io.rd_address       = rda_q;
  assign bus_io.wb_done          = done_q;
  assign bus_io.fault_misaligned = fmis_q;
  assign bus_io.fault_illegal    = fill_q;
  assign bus_io.fault_timeout    = fto_q;
  // State and registered outputs; reset drops mem_req and any pending load at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      mem_req_q <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      fmis_q    <= 1'b0;
      fill_q    <= 1'b0;
      fto_q     <= 1'b0;
      rd_q      <= '0;
      rda_q     <= '0;
      f3_q      <= '0;
      off_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      mem_req_q <= mem_req_d;
      we_q      <= we_d;
      done_q    <= done_d;
      fmis_q    <= fmis_d;
      fill_q    <= fill_d;
      fto_q     <= fto_d;
      rd_q      <= rd_d;
      rda_q     <= rda_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
    end
  end
  // Next state and next registered outputs; pulses are set on the transition so they land one cycle later
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_req_d = 1'b0;
    we_d      = 1'b0;
    done_d    = 1'b0;
    fmis_d    = 1'b0;
    fill_d    = 1'b0;
    fto_d     = 1'b0;
    rd_d      = rd_q;
    rda_d     = rda_q;
    f3_d      = f3_q;
    off_d     = off_q;
    unique case (state_q)
      IDLE: if (bus_io.instr_valid) begin
        f3_d  = bus_io.load_funct3;
        off_d = bus_io.load_byte_offset;
        rda_d = RV32I != 0 ? bus_io.rd_address_in : {1'b0, bus_io.rd_address_in[3:0]};
        done_d = 1'b1;
        if (illegal) fill_d = 1'b1;
        else if (is_load && misaligned) fmis_d = 1'b1;
        else if (bus_io.wb_source == 3'd0 || bus_io.rd_address_in == 5'd0) done_d = 1'b1;
        else if (is_load) begin
          done_d    = 1'b0;
          state_d   = LOAD_WAIT;
          mem_req_d = 1'b1;
          cnt_d     = '0;
        end else begin
          state_d = WRITE;
          we_d    = 1'b1;
          rd_d    = src_data;
        end
      end
      LOAD_WAIT: if (bus_io.mem_ack) begin
        state_d = WRITE;
        we_d    = 1'b1;
        done_d  = 1'b1;
        rd_d    = ld_data;
      end else if (cnt_q == TO_LAST) begin
        state_d = IDLE;
        fto_d   = 1'b1;
        done_d  = 1'b1;
      end else begin
        mem_req_d = 1'b1;
        cnt_d     = cnt_q + 10'd1;
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
  end
endmodule

// File: tb/tb_writeback_sequencer.sv
// tb_writeback_sequencer: directed scoreboard bench for writeback_sequencer (RV32E, LOAD_TIMEOUT=8)
module tb_writeback_sequencer;
  typedef struct packed {
    logic        we;
    logic        fmis;
    logic        fill;
    logic        fto;
    logic        done;
    logic [4:0]  addr;
    logic [31:0] data;
  } ev_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;
  int req_cycles = 0;
  ev_t exp_q[$];
  ev_t mon_obs, mon_exp;
  writeback_sequencer_if bus();
  writeback_sequencer #(.RV32I(0), .LOAD_TIMEOUT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus_io(bus)
  );
  always #5 clock = ~clock;
  function automatic ev_t wr(input logic [4:0] a, input logic [31:0] d);
    return '{we: 1'b1, fmis: 1'b0, fill: 1'b0, fto: 1'b0, done: 1'b1, addr: a, data: d};
  endfunction
  function automatic ev_t st(input logic fmis, input logic fill, input logic fto);
    return '{we: 1'b0, fmis: fmis, fill: fill, fto: fto, done: 1'b1, addr: 5'd0, data: 32'd0};
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  // Any output event pops one expected event; an event with nothing queued compares against all-zero
  always @(negedge clock) if (!reset) begin
    if (bus.mem_req) req_cycles++;
    if (bus.wb_done | bus.rd_write_enable | bus.fault_misaligned | bus.fault_illegal | bus.fault_timeout) begin
      mon_obs = '{we: bus.rd_write_enable, fmis: bus.fault_misaligned, fill: bus.fault_illegal,
                  fto: bus.fault_timeout, done: bus.wb_done,
                  addr: bus.rd_write_enable ? bus.rd_address : 5'd0,
                  data: bus.rd_write_enable ? bus.rd : 32'd0};
      mon_exp = exp_q.size() != 0 ? exp_q.pop_front() : '0;
      check("event", 64'(mon_obs), 64'(mon_exp));
    end
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic send(input logic [2:0] src, input logic [4:0] a, input logic [31:0] v,
                      input logic [2:0] f3, input logic [1:0] off);
    logic r, acc;
    acc = 1'b0;
    bus.wb_source        = src;
    bus.rd_address_in    = a;
    bus.alu_result       = src == 3'd1 ? v : 32'h1111_1111;
    bus.pc_plus_4        = src == 3'd2 ? v : 32'h2222_2222;
    bus.immediate        = src == 3'd3 ? v : 32'h3333_3333;
    bus.load_funct3      = f3;
    bus.load_byte_offset = off;
    bus.instr_valid      = 1'b1;
    for (int i = 0; i < 16 && !acc; i++) begin
      r = bus.instr_ready;
      @(posedge clock);
      #1;
      acc = r;
    end
    bus.instr_valid = 1'b0;
    check("accept", 64'(acc), 64'(1'b1));
  endtask
  task automatic ack_after(input int n, input logic [31:0] d);
    for (int i = 1; i < n; i++) begin
      @(posedge clock);
      #1;
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = d;
    @(posedge clock);
    #1;
    bus.mem_ack = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.instr_valid      = 1'b0;
    bus.wb_source        = '0;
    bus.rd_address_in    = '0;
    bus.alu_result       = '0;
    bus.pc_plus_4        = '0;
    bus.immediate        = '0;
    bus.load_funct3      = '0;
    bus.load_byte_offset = '0;
    bus.mem_ack          = 1'b0;
    bus.mem_rdata        = '0;
    @(negedge clock);
    check("reset_state",
          64'({bus.instr_ready, bus.mem_req, bus.rd_write_enable, bus.wb_done, bus.fault_misaligned,
               bus.fault_illegal, bus.fault_timeout, bus.rd_address, bus.rd}),
          64'({1'b1, 6'd0, 5'd0, 32'd0}));
    idle(2);
    reset = 1'b0;
    idle(1);
    exp_q.push_back(wr(5'd5, 32'hDEAD_BEEF));
    send(3'd1, 5'd5, 32'hDEAD_BEEF, 3'd0, 2'd0);
    check("alu_latency", 64'({bus.rd_write_enable, bus.rd_address}), 64'({1'b1, 5'd5}));
    exp_q.push_back(wr(5'd3, 32'h0000_1004));
    send(3'd2, 5'd3, 32'h0000_1004, 3'd0, 2'd0);
    exp_q.push_back(wr(5'd9, 32'hABCD_E000));
    send(3'd3, 5'd9, 32'hABCD_E000, 3'd0, 2'd0);
    exp_q.push_back(st(1'b0, 1'b0, 1'b0));
    send(3'd1, 5'd0, 32'h1234_5678, 3'd0, 2'd0);
    exp_q.push_back(st(1'b0, 1'b0, 1'b0));
    send(3'd0, 5'd4, 32'h1234_5678, 3'd0, 2'd0);
    exp_q.push_back(st(1'b0, 1'b1, 1'b0));
    send(3'd1, 5'd17, 32'h1234_5678, 3'd0, 2'd0);
    exp_q.push_back(st(1'b0, 1'b1, 1'b0));
    send(3'd6, 5'd4, 32'h1234_5678, 3'd0, 2'd0);
    exp_q.push_back(st(1'b0, 1'b1, 1'b0));
    send(3'd4, 5'd4, 32'h0, 3'd3, 2'd0);
    idle(2);
    req_cycles = 0;
    exp_q.push_back(st(1'b1, 1'b0, 1'b0));
    send(3'd4, 5'd6, 32'h0, 3'd2, 2'd2);
    exp_q.push_back(st(1'b1, 1'b0, 1'b0));
    send(3'd4, 5'd0, 32'h0, 3'd1, 2'd1);
    idle(3);
    check("misaligned_no_req", 64'(req_cycles), 64'(0));
    req_cycles = 0;
    exp_q.push_back(wr(5'd8, 32'hFFFF_FF80));
    send(3'd4, 5'd8, 32'h0, 3'd0, 2'd3);
    ack_after(4, 32'h8011_2233);
    idle(2);
    check("lb_req_cycles", 64'(req_cycles), 64'(4));
    exp_q.push_back(wr(5'd8, 32'h0000_0080));
    send(3'd4, 5'd8, 32'h0, 3'd4, 2'd3);
    ack_after(2, 32'h8011_2233);
    exp_q.push_back(wr(5'd11, 32'hFFFF_8011));
    send(3'd4, 5'd11, 32'h0, 3'd1, 2'd2);
    ack_after(1, 32'h8011_2233);
    exp_q.push_back(wr(5'd12, 32'h0000_2233));
    send(3'd4, 5'd12, 32'h0, 3'd5, 2'd0);
    ack_after(3, 32'h8011_2233);
    idle(2);
    req_cycles = 0;
    exp_q.push_back(wr(5'd13, 32'h8011_2233));
    send(3'd4, 5'd13, 32'h0, 3'd2, 2'd0);
    ack_after(8, 32'h8011_2233);
    idle(2);
    check("ack_at_timeout_req", 64'(req_cycles), 64'(8));
    req_cycles = 0;
    exp_q.push_back(st(1'b0, 1'b0, 1'b1));
    send(3'd4, 5'd7, 32'h0, 3'd2, 2'd0);
    idle(12);
    check("timeout_req_cycles", 64'(req_cycles), 64'(8));
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    idle(2);
    bus.mem_ack = 1'b0;
    send(3'd4, 5'd10, 32'h0, 3'd0, 2'd0);
    idle(2);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", 64'({bus.mem_req, bus.instr_ready, bus.rd_write_enable}), 64'({1'b0, 1'b1, 1'b0}));
    idle(2);
    reset = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h8011_2233;
    idle(1);
    bus.mem_ack = 1'b0;
    idle(3);
    exp_q.push_back(wr(5'd15, 32'h0BAD_CAFE));
    send(3'd1, 5'd15, 32'h0BAD_CAFE, 3'd0, 2'd0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    check("drain", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
